// File: rtl/scan_gen_param.sv
// ============================================================================
// Module  : scan_gen_param
// Purpose : ROWS x COLS buffer scan sequencer with row/column-major order,
//           valid/ready backpressure, continuous re-scan, abort and done pulse.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module scan_gen_param #(
    parameter int ROWS   = 64,
    parameter int COLS   = 256,
    parameter int ADDR_W = 14,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              cont_i,
    input  logic              abort_i,
    input  logic              addr_ready_i,
    output logic [ADDR_W-1:0] read_select_o,
    output logic [RW-1:0]     row_idx_o,
    output logic [CW-1:0]     col_idx_o,
    output logic              addr_valid_o,
    output logic              scan_start_o,
    output logic              scan_done_o,
    output logic              busy_o
);

    localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(COLS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              done_q, done_d;
    logic              mode_q, mode_d;
    logic              cont_q, cont_d;
    logic              start_prev_q, start_prev_d;

    logic              start_edge;
    logic              beat;
    logic              last;

    assign start_edge = start_i & ~start_prev_q;
    assign beat       = valid_q & addr_ready_i;
    assign last       = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            base_q       <= '0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            done_q       <= 1'b0;
            mode_q       <= 1'b0;
            cont_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            done_q       <= done_d;
            mode_q       <= mode_d;
            cont_q       <= cont_d;
            start_prev_q <= start_prev_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        base_d       = base_q;
        valid_d      = valid_q;
        first_d      = 1'b0;
        done_d       = 1'b0;
        mode_d       = mode_q;
        cont_d       = cont_q;
        start_prev_d = start_i;

        case (state_q)
            S_IDLE: begin
                if (start_edge && !abort_i) begin
                    state_d = S_SCAN;
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    mode_d  = mode_i;
                    cont_d  = cont_i;
                    row_d   = '0;
                    col_d   = '0;
                    base_d  = '0;
                end
            end
            S_SCAN: begin
                if (beat && last) begin
                    // A last beat still completes even when abort arrives with it.
                    done_d = 1'b1;
                    row_d  = '0;
                    col_d  = '0;
                    base_d = '0;
                    if (cont_q && !abort_i) begin
                        first_d = 1'b1;
                        mode_d  = mode_i;
                        cont_d  = cont_i;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end
                end else if (abort_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    base_d  = '0;
                end else if (beat) begin
                    if (!mode_q) begin
                        if (col_q == COL_LAST) begin
                            col_d  = '0;
                            row_d  = row_q + RW'(1);
                            base_d = base_q + STRIDE;
                        end else begin
                            col_d  = col_q + CW'(1);
                        end
                    end else begin
                        if (row_q == ROW_LAST) begin
                            row_d  = '0;
                            base_d = '0;
                            col_d  = col_q + CW'(1);
                        end else begin
                            row_d  = row_q + RW'(1);
                            base_d = base_q + STRIDE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Row base tracks row*COLS, so the address needs only an add.
        addr_d = base_d + ADDR_W'(col_d);
    end

    assign read_select_o = addr_q;
    assign row_idx_o     = row_q;
    assign col_idx_o     = col_q;
    assign addr_valid_o  = valid_q;
    assign scan_start_o  = first_q;
    assign scan_done_o   = done_q;
    assign busy_o        = (state_q == S_SCAN);

endmodule

`default_nettype wire

// File: tb/tb_scan_gen_param.sv
// ============================================================================
// Module  : tb_scan_gen_param
// Purpose : Self-checking bench for scan_gen_param (ROWS=4, COLS=3).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_scan_gen_param;

    localparam int ROWS   = 4;
    localparam int COLS   = 3;
    localparam int ADDR_W = 6;
    localparam int N      = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic              cont = 1'b0;
    logic              abort = 1'b0;
    logic              addr_ready = 1'b1;
    logic [ADDR_W-1:0] read_select;
    logic [1:0]        row_idx;
    logic [1:0]        col_idx;
    logic              addr_valid;
    logic              scan_start;
    logic              scan_done;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    scan_gen_param #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .mode_i       (mode),
        .cont_i       (cont),
        .abort_i      (abort),
        .addr_ready_i (addr_ready),
        .read_select_o(read_select),
        .row_idx_o    (row_idx),
        .col_idx_o    (col_idx),
        .addr_valid_o (addr_valid),
        .scan_start_o (scan_start),
        .scan_done_o  (scan_done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Abstract model: a pass is a beat counter k; order maps k to (row, col).
    int m_k = 0;
    bit m_busy = 0, m_mode = 0, m_cont = 0, m_sp = 0, m_first = 0, m_done = 0;
    bit m_edge;

    function automatic int m_row();
        return m_mode ? (m_k % ROWS) : (m_k / COLS);
    endfunction
    function automatic int m_col();
        return m_mode ? (m_k / ROWS) : (m_k % COLS);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_busy = 0; m_mode = 0; m_cont = 0;
            m_sp = 0; m_first = 0; m_done = 0;
        end else begin
            m_edge  = start && !m_sp;
            m_sp    = start;
            m_first = 0;
            m_done  = 0;
            if (!m_busy) begin
                if (m_edge && !abort) begin
                    m_busy = 1; m_k = 0; m_mode = mode; m_cont = cont; m_first = 1;
                end
            end else if (addr_ready && m_k == N - 1) begin
                m_done = 1;
                m_k    = 0;
                if (m_cont && !abort) begin
                    m_first = 1; m_mode = mode; m_cont = cont;
                end else begin
                    m_busy = 0;
                end
            end else if (abort) begin
                m_busy = 0; m_k = 0;
            end else if (addr_ready) begin
                m_k++;
            end
        end
    end

    int acc_q[$];
    int cnt5 = 0;
    bit sim_end = 0;

    always @(negedge clk) begin
        if (!sim_end) begin
            chk("addr_valid", 32'(addr_valid), 32'(m_busy));
            chk("read_select", 32'(read_select), 32'(m_row() * COLS + m_col()));
            chk("row_idx", 32'(row_idx), 32'(m_row()));
            chk("col_idx", 32'(col_idx), 32'(m_col()));
            chk("scan_start", 32'(scan_start), 32'(m_first));
            chk("scan_done", 32'(scan_done), 32'(m_done));
            chk("busy", 32'(busy), 32'(m_busy));
            if (addr_valid && addr_ready) acc_q.push_back(int'(read_select));
            if (addr_valid && read_select == 5) cnt5++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            step();
            if (!busy) return;
        end
        chk({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_addr(input int a, input string name);
        for (int i = 0; i < 40; i++) begin
            if (addr_valid && read_select == ADDR_W'(a)) return;
            step();
        end
        chk({name, "_addr_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_log(input string name, input int exp[$]);
        chk({name, "_len"}, 32'(acc_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
            chk(name, 32'(acc_q[i]), 32'(exp[i]));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_sel"}, 32'(read_select), 32'd0);
        chk({name, "_row"}, 32'(row_idx), 32'd0);
        chk({name, "_col"}, 32'(col_idx), 32'd0);
        chk({name, "_ctl"}, 32'({addr_valid, scan_start, scan_done, busy}), 32'd0);
    endtask

    initial begin
        int exp_q[$];
        int dones;

        #3 rst_n = 1'b0;
        #1 check_zero("reset_async");
        // Inputs toggling under reset must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            start = ~start; mode = ~mode; cont = ~cont; abort = ~abort;
            step();
            check_zero("reset_hold");
        end
        start = 0; mode = 0; cont = 0; abort = 0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("idle_no_start", 32'(busy), 32'd0);

        // Row-major single pass.
        acc_q.delete();
        pulse_start();
        chk("first_sel", 32'(read_select), 32'd0);
        chk("first_start", 32'(scan_start), 32'd1);
        wait_idle("rowmaj");
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        check_log("rowmaj_seq", exp_q);

        // Column-major single pass.
        acc_q.delete();
        mode = 1'b1;
        pulse_start();
        mode = 1'b0;
        wait_idle("colmaj");
        exp_q = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        check_log("colmaj_seq", exp_q);

        // Backpressure on address 5.
        acc_q.delete();
        cnt5 = 0;
        pulse_start();
        wait_addr(5, "stall");
        addr_ready = 1'b0;
        repeat (3) step();
        addr_ready = 1'b1;
        wait_idle("stall");
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        check_log("stall_seq", exp_q);
        chk("stall_hold_cycles", 32'(cnt5), 32'd4);

        // Continuous mode with start held high, then cont cleared.
        acc_q.delete();
        cont  = 1'b1;
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 100 && dones < 2; i++) begin
            step();
            if (scan_done) begin
                dones++;
                chk("cont_boundary_start", 32'(scan_start), 32'd1);
                chk("cont_boundary_sel", 32'(read_select), 32'd0);
            end
        end
        chk("cont_two_dones", 32'(dones), 32'd2);
        cont = 1'b0;
        wait_idle("cont");
        repeat (5) step();
        chk("cont_no_retrigger", 32'(busy), 32'd0);
        start = 1'b0;
        chk("cont_len", 32'(acc_q.size()), 32'd48);
        for (int i = 0; i < acc_q.size(); i++)
            chk("cont_seq", 32'(acc_q[i]), 32'(i % N));

        // Abort in idle together with a start edge.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        repeat (2) step();
        chk("idle_abort_wins", 32'(busy), 32'd0);

        // Abort mid-scan while stalled on address 7.
        acc_q.delete();
        pulse_start();
        wait_addr(7, "abort7");
        abort = 1'b1; addr_ready = 1'b0;
        step();
        abort = 1'b0; addr_ready = 1'b1;
        chk("abort7_idle", 32'(busy), 32'd0);
        chk("abort7_no_done", 32'(scan_done), 32'd0);
        exp_q = '{0, 1, 2, 3, 4, 5, 6};
        check_log("abort7_seq", exp_q);

        // Abort coinciding with the last beat, with cont set.
        acc_q.delete();
        cont = 1'b1;
        pulse_start();
        wait_addr(11, "abort11");
        abort = 1'b1;
        step();
        abort = 1'b0; cont = 1'b0;
        chk("abort11_done", 32'(scan_done), 32'd1);
        chk("abort11_idle", 32'(busy), 32'd0);
        chk("abort11_no_restart", 32'(scan_start), 32'd0);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        check_log("abort11_seq", exp_q);

        // Asynchronous reset mid-scan.
        pulse_start();
        wait_addr(4, "midrst");
        rst_n = 1'b0;
        #1 check_zero("midrst");
        step();
        check_zero("midrst_hold");
        rst_n = 1'b1;
        repeat (3) step();
        chk("midrst_after", 32'(busy), 32'd0);

        sim_end = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
